// File: rtl/mem_proto_pkg.sv
// ============================================================================
// Module  : mem_proto_pkg
// Brief   : Opcodes and FSM state encodings for the memory-controller byte
//           protocol, shared by the initiator, mem_controller and benches.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package mem_proto_pkg;

    localparam logic [7:0] CMD_READ  = 8'd48;
    localparam logic [7:0] CMD_WRITE = 8'd49;

    localparam logic [1:0] C_IDLE = 2'd0;
    localparam logic [1:0] C_CMD  = 2'd1;
    localparam logic [1:0] C_ADDR = 2'd2;
    localparam logic [1:0] C_DATA = 2'd3;

    localparam logic [1:0] R_IDLE = 2'd0;
    localparam logic [1:0] R_POP  = 2'd1;
    localparam logic [1:0] R_HOLD = 2'd2;

    function automatic logic [7:0] cmd_opcode(input logic is_write);
        return is_write ? CMD_WRITE : CMD_READ;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_cmd_initiator_if.sv
// ============================================================================
// Module  : mem_cmd_initiator_if
// Brief   : Request, command-FIFO, response-FIFO and response signal bundle
//           of the memory command initiator.
// Rev     : 1.0
// ============================================================================
`default_nettype none

interface mem_cmd_initiator_if #(
    parameter int WIDTH = 8
);
    logic             req_valid;
    logic             req_ready;
    logic             req_write;
    logic [WIDTH-1:0] req_addr;
    logic [WIDTH-1:0] req_data;
    logic             cmd_fifo_full;
    logic             cmd_fifo_wr_en;
    logic [WIDTH-1:0] cmd_fifo_din;
    logic             rsp_fifo_empty;
    logic             rsp_fifo_rd_en;
    logic [WIDTH-1:0] rsp_fifo_dout;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic [WIDTH-1:0] rsp_addr;
    logic             rsp_unexpected;

    modport master (
        input  req_valid, req_write, req_addr, req_data,
        input  cmd_fifo_full, rsp_fifo_empty, rsp_fifo_dout, rsp_ready,
        output req_ready, cmd_fifo_wr_en, cmd_fifo_din, rsp_fifo_rd_en,
        output rsp_valid, rsp_data, rsp_addr, rsp_unexpected
    );

    modport slave (
        output req_valid, req_write, req_addr, req_data,
        output cmd_fifo_full, rsp_fifo_empty, rsp_fifo_dout, rsp_ready,
        input  req_ready, cmd_fifo_wr_en, cmd_fifo_din, rsp_fifo_rd_en,
        input  rsp_valid, rsp_data, rsp_addr, rsp_unexpected
    );
endinterface

`default_nettype wire

// File: rtl/mem_tag_queue.sv
// ============================================================================
// Module  : mem_tag_queue
// Brief   : Small synchronous FIFO of outstanding read addresses; dout shows
//           the entry at the read pointer combinationally.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module mem_tag_queue #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_push,
    input  wire logic [WIDTH-1:0] i_din,
    input  wire logic             i_pop,
    output logic      [WIDTH-1:0] o_dout
);
    localparam int c_PW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_PW-1:0]  r_wr_ptr;
    logic [c_PW-1:0]  r_rd_ptr;

    // DEPTH is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr_ptr] <= i_din;
    end

    assign o_dout = r_mem[r_rd_ptr];
endmodule

`default_nettype wire

// File: rtl/mem_cmd_initiator.sv
// ============================================================================
// Module  : mem_cmd_initiator
// Brief   : Serialises word requests into command-FIFO bytes and returns
//           address-tagged read data. MEM_CMD_INITIATOR_STATS_EN adds counters.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module mem_cmd_initiator
    import mem_proto_pkg::*;
#(
    parameter int WIDTH           = 8,
    parameter int MAX_OUTSTANDING = 8
) (
    input  wire logic            clk,
    input  wire logic            rst,
    mem_cmd_initiator_if.master  bus
`ifdef MEM_CMD_INITIATOR_STATS_EN
    ,
    output logic [15:0]          stat_writes,
    output logic [15:0]          stat_reads,
    output logic [7:0]           stat_unexpected
`endif
);
    localparam int                c_OW      = $clog2(MAX_OUTSTANDING) + 1;
    localparam logic [c_OW-1:0]   c_MAX_OUT = c_OW'(MAX_OUTSTANDING);

    logic [1:0]       r_cstate;
    logic [1:0]       r_rstate;
    logic             r_write;
    logic [WIDTH-1:0] r_addr;
    logic [WIDTH-1:0] r_data;
    logic [c_OW-1:0]  r_outstanding;
    logic [WIDTH-1:0] r_rsp_data;
    logic [WIDTH-1:0] r_rsp_addr;
    logic             r_unexp;

    logic             w_req_ready;
    logic             w_wr_en;
    logic [WIDTH-1:0] w_din;
    logic             w_accept;
    logic             w_rd_accept;
    logic             w_rd_en;
    logic             w_rsp_hs;
    logic             w_have_out;
    logic             w_tag_pop;
    logic [WIDTH-1:0] w_tag_dout;

    // req_ready and rd_en are masked while rst is held so every output reads 0.
    always_comb begin
        w_req_ready = 1'b0;
        w_wr_en     = 1'b0;
        w_din       = '0;
        case (r_cstate)
            C_IDLE: w_req_ready = !rst && (bus.req_write || (r_outstanding < c_MAX_OUT));
            C_CMD: begin
                w_wr_en = !bus.cmd_fifo_full;
                w_din   = WIDTH'(cmd_opcode(r_write));
            end
            C_ADDR: begin
                w_wr_en = !bus.cmd_fifo_full;
                w_din   = r_addr;
            end
            C_DATA: begin
                w_wr_en = !bus.cmd_fifo_full;
                w_din   = r_data;
            end
            default: ;
        endcase
    end

    assign w_accept    = bus.req_valid && w_req_ready;
    assign w_rd_accept = w_accept && !bus.req_write;
    assign w_rd_en     = !rst && (r_rstate == R_IDLE) && !bus.rsp_fifo_empty;
    assign w_rsp_hs    = (r_rstate == R_HOLD) && bus.rsp_ready;
    assign w_have_out  = (r_outstanding != '0);
    assign w_tag_pop   = (r_rstate == R_POP) && w_have_out;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cstate <= C_IDLE;
            r_write  <= 1'b0;
            r_addr   <= '0;
            r_data   <= '0;
        end else begin
            case (r_cstate)
                C_IDLE: if (w_accept) begin
                    r_write  <= bus.req_write;
                    r_addr   <= bus.req_addr;
                    r_data   <= bus.req_data;
                    r_cstate <= C_CMD;
                end
                C_CMD:  if (w_wr_en) r_cstate <= C_ADDR;
                C_ADDR: if (w_wr_en) r_cstate <= r_write ? C_DATA : C_IDLE;
                C_DATA: if (w_wr_en) r_cstate <= C_IDLE;
                default: r_cstate <= C_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rstate   <= R_IDLE;
            r_rsp_data <= '0;
            r_rsp_addr <= '0;
            r_unexp    <= 1'b0;
        end else begin
            r_unexp <= 1'b0;
            case (r_rstate)
                R_IDLE: if (w_rd_en) r_rstate <= R_POP;
                R_POP: begin
                    if (w_have_out) begin
                        r_rsp_data <= bus.rsp_fifo_dout;
                        r_rsp_addr <= w_tag_dout;
                        r_rstate   <= R_HOLD;
                    end else begin
                        r_unexp  <= 1'b1;
                        r_rstate <= R_IDLE;
                    end
                end
                R_HOLD: if (bus.rsp_ready) r_rstate <= R_IDLE;
                default: r_rstate <= R_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_outstanding <= '0;
        end else begin
            case ({w_rd_accept, w_rsp_hs})
                2'b10:   r_outstanding <= r_outstanding + 1'b1;
                2'b01:   r_outstanding <= r_outstanding - 1'b1;
                default: ;
            endcase
        end
    end

    mem_tag_queue #(
        .WIDTH (WIDTH),
        .DEPTH (MAX_OUTSTANDING)
    ) u_tag_queue (
        .clk    (clk),
        .rst    (rst),
        .i_push (w_rd_accept),
        .i_din  (bus.req_addr),
        .i_pop  (w_tag_pop),
        .o_dout (w_tag_dout)
    );

    assign bus.req_ready      = w_req_ready;
    assign bus.cmd_fifo_wr_en = w_wr_en;
    assign bus.cmd_fifo_din   = w_din;
    assign bus.rsp_fifo_rd_en = w_rd_en;
    assign bus.rsp_valid      = (r_rstate == R_HOLD);
    assign bus.rsp_data       = r_rsp_data;
    assign bus.rsp_addr       = r_rsp_addr;
    assign bus.rsp_unexpected = r_unexp;

`ifdef MEM_CMD_INITIATOR_STATS_EN
    logic [15:0] r_stat_writes;
    logic [15:0] r_stat_reads;
    logic [7:0]  r_stat_unexp;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_writes <= '0;
            r_stat_reads  <= '0;
            r_stat_unexp  <= '0;
        end else begin
            if ((r_cstate == C_DATA) && w_wr_en) r_stat_writes <= r_stat_writes + 1'b1;
            if (w_rsp_hs)                        r_stat_reads  <= r_stat_reads + 1'b1;
            if (r_unexp)                         r_stat_unexp  <= r_stat_unexp + 1'b1;
        end
    end

    assign stat_writes     = r_stat_writes;
    assign stat_reads      = r_stat_reads;
    assign stat_unexpected = r_stat_unexp;
`endif
endmodule

`default_nettype wire
